// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit-check helper for the
// reverse double-dabble BCD-to-binary converter.
package bcd_pkg;

    localparam int BIN_W = 8;                // result width and iteration count
    localparam int NDIG  = 3;                // number of BCD input digits
    localparam int BCD_W = 4 * NDIG;         // packed BCD width
    localparam int SR_W  = BCD_W + BIN_W;    // {bcd, acc} shift register width
    localparam int CNT_W = $clog2(BIN_W);    // iteration counter width

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] RDD_THRESH    = 4'd8;
    localparam logic [3:0] RDD_ADJ       = 4'd3;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // True when any packed nibble is not a legal decimal digit.
    function automatic logic bcd_has_invalid(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > BCD_DIGIT_MAX) bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Request/result bundle for the BCD-to-binary converter.
// master = requester (keypad/register side), slave = converter.
interface bcd_to_bin_seq_if;
    import bcd_pkg::*;

    logic             start;
    logic [BCD_W-1:0] bcd_in;
    logic             busy;
    logic             done;
    logic [BIN_W-1:0] bin;
    logic             ovf;
    logic             err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin, ovf, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin, ovf, err
    );

endinterface

// File: rtl/bcd_to_bin_seq_rdd_digit_adj.sv
// Reverse double-dabble correction cell: after a right shift, a BCD
// digit that reads 8 or more received a borrowed half-ten (8 instead
// of 5), so 3 is taken back off.
module rdd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Conditional subtract-3 on a single shifted digit.
    always_comb begin
        q = (d >= RDD_THRESH) ? (d - RDD_ADJ) : d;
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// One shift-and-correct iteration per clock; 8 iterations per conversion.
// Invalid digits are rejected in one cycle with err set and bin forced to 0.
module bcd_to_bin_seq
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    bcd_to_bin_seq_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [BIN_W-1:0]   acc_q,   acc_d;
    logic [BIN_W-1:0]   bin_q,   bin_d;
    logic               ovf_q,   ovf_d;
    logic               err_q,   err_d;
    logic               done_q,  done_d;

    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BIN_W-1:0]   acc_shift;
    logic               last_iter;

    // One right shift of the combined {bcd, acc} register per iteration.
    always_comb begin
        sr_shift  = {bcd_q, acc_q} >> 1;
        acc_shift = sr_shift[BIN_W-1:0];
        last_iter = (count_q == CNT_W'(BIN_W - 1));
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        rdd_digit_adj u_adj (
            .d (sr_shift[BIN_W + 4*g +: 4]),
            .q (bcd_adj[4*g +: 4])
        );
    end

    // Next-state and datapath update for the IDLE/CONV controller.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bcd_has_invalid(bus.bcd_in)) begin
                        err_d  = 1'b1;
                        ovf_d  = 1'b0;
                        bin_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        bcd_d   = bus.bcd_in;
                        acc_d   = '0;
                        count_d = '0;
                        err_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                bcd_d   = bcd_adj;
                acc_d   = acc_shift;
                count_d = count_q + 1'b1;
                if (last_iter) begin
                    // Anything left in the BCD field is the part above 255.
                    bin_d   = acc_shift;
                    ovf_d   = |bcd_adj;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            bcd_q   <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Outputs come straight from registers; busy is the CONV state itself.
    always_comb begin
        bus.busy = (state_q == CONV);
        bus.done = done_q;
        bus.bin  = bin_q;
        bus.ovf  = ovf_q;
        bus.err  = err_q;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Sequential BCD-to-binary converter: the inverse of the team's BCD adder/display path, which turns binary-coded sums into BCD digits for 7-segment output.
- Accepts a 3-digit packed BCD value (hundreds, tens, ones) on a start strobe and converts it with reverse double-dabble: shift right, then subtract 3 from any digit >= 8.
- Produces an 8-bit binary result with done/busy handshake plus overflow and invalid-digit flags.
- Sits between BCD keypad/register entry and binary datapath logic.

Parameters:
- BIN_W, 8, binary result width and iteration count; fixed at 8 for this revision.
- NDIG, 3, number of BCD input digits; fixed at 3 for this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only while idle.
- bcd_in  input  12  packed BCD {hundreds[11:8], tens[7:4], ones[3:0]}.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin/ovf/err are valid.
- bin  output  8  binary result; holds its value until the next done.
- ovf  output  1  value exceeded 255; bin holds value mod 256.
- err  output  1  some input digit > 9; bin forced to 0.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - FSM state = IDLE.
  - busy = 0, done = 0, bin = 0x00, ovf = 0, err = 0.
  - Internal 20-bit shift register {bcd[11:0], acc[7:0]} = 0; iteration counter = 0.
- FSM has two states, IDLE and CONV.
- IDLE, start = 1 at edge E0:
  - If any nibble of bcd_in > 9: err <= 1, ovf <= 0, bin <= 0, done <= 1, stay IDLE. Latency is 1 cycle.
  - Otherwise: load bcd <= bcd_in, acc <= 0, count <= 0, busy <= 1, go to CONV. Clear err and ovf at this edge.
- CONV, each edge:
  - One full iteration: shift {bcd, acc} right by 1; then in each of the 3 shifted BCD nibbles, if the nibble >= 8, subtract 3. Shift and correct complete in the same cycle.
  - count increments.
  - On the 8th iteration (edge E8): bin <= resulting acc, ovf <= (resulting bcd != 0), done <= 1, busy <= 0, go to IDLE.
- Latency: done is high in the cycle following E8, i.e. 8 cycles after start is sampled. The next start is accepted at the same edge that clears done.
- done is high for exactly one cycle. It is deasserted at the next edge unless a new invalid-digit request generates another done.
- start while busy is ignored; bcd_in changes during CONV have no effect.
- start held continuously: a new conversion begins on every idle cycle (back-to-back).
- rst asserted mid-conversion: abort immediately to reset values; no done is produced.
- Simultaneous rst and start: rst wins.
- bin, ovf and err hold their values between done pulses.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_MAX = 4'd9
  - RDD_THRESH = 4'd8
  - RDD_ADJ = 4'd3
  - NDIG and BIN_W constants
  - FSM state encoding (IDLE = 1'b0, CONV = 1'b1)
- One natural sub-module: rdd_digit_adj, a combinational 4-bit "if >= 8 subtract 3" cell, instantiated NDIG times inside the iteration logic.

Test Plan:
- Reset, then bcd_in = 12'h199, start for 1 cycle -> busy high for 8 cycles; done pulse 8 cycles after start; bin = 8'hC7, ovf = 0, err = 0.
- bcd_in = 12'h000, then 12'h255 (back-to-back, start held) -> bin = 8'h00, then bin = 8'hFF; two done pulses 9 cycles apart; ovf = 0 both times.
- bcd_in = 12'h256 -> done after 8 cycles; bin = 8'h00, ovf = 1. Then bcd_in = 12'h999 -> bin = 8'hE7 (999 mod 256), ovf = 1.
- bcd_in = 12'h1A3 -> done on the next cycle; err = 1, bin = 8'h00, busy never asserts. Follow with 12'h042 -> bin = 8'h2A, err = 0.
- Start with 12'h123; at cycle 3 pulse start with 12'h050 -> second start ignored; bin = 8'h7B; exactly one done.
- Start with 12'h200; assert rst at cycle 4 -> all outputs 0 on the next cycle, no done. Restart with 12'h200 -> bin = 8'hC8.
